// File: rtl/req_unit_gen.sv
// Memory request unit: issues instruction fetches, latches one data request per
// fetch, optionally holds fetch while data is pending, times out stuck requests.
module req_unit_gen #(
  parameter int CNT_W   = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200,
  parameter int IHOLD   = 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             DatRead,
  input  logic             DatWrite,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             halt,
  input  logic             flush,
  output logic             ReqiREN,
  output logic             ReqdREN,
  output logic             ReqdWEN,
  output logic             busy,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] icount,
  output logic [CNT_W-1:0] dcount
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DATA = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic             HOLD_I   = (IHOLD != 0);

  state_t          state, nextState;
  logic            nextREN, nextWEN, nextErr;
  logic [TO_W-1:0] toCnt, nextTo;
  logic            incI, incD;
  logic            dataOp, fetchOk;

  assign dataOp = DatRead | DatWrite;
  assign busy   = (state == DATA);
  assign halted = (state == HALT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      ReqdREN     <= 1'b0;
      ReqdWEN     <= 1'b0;
      timeout_err <= 1'b0;
      toCnt       <= '0;
      icount      <= '0;
      dcount      <= '0;
    end else begin
      state       <= nextState;
      ReqdREN     <= nextREN;
      ReqdWEN     <= nextWEN;
      timeout_err <= nextErr;
      toCnt       <= nextTo;
      if (incI) icount <= icount + CNT_ONE;
      if (incD) dcount <= dcount + CNT_ONE;
    end
  end

  always_comb begin
    nextState = state;
    nextREN   = ReqdREN;
    nextWEN   = ReqdWEN;
    nextErr   = timeout_err;
    nextTo    = toCnt;
    incI      = 1'b0;
    incD      = 1'b0;
    ReqiREN   = 1'b0;
    fetchOk   = 1'b0;
    case (state)
      RUN: begin
        ReqiREN = 1'b1;
        if (ihit) incI = 1'b1;
        if (ihit && dataOp) begin
          // A write wins when the decoder flags both, so the two requests never overlap.
          nextState = DATA;
          nextREN   = DatRead & ~DatWrite;
          nextWEN   = DatWrite;
          nextTo    = '0;
        end else if (halt) begin
          nextState = HALT;
        end
      end
      DATA: begin
        ReqiREN = ~HOLD_I;
        fetchOk = ~HOLD_I & ihit;
        if (dhit) begin
          incD = 1'b1;
          incI = fetchOk;
          if (fetchOk && dataOp) begin
            nextREN = DatRead & ~DatWrite;
            nextWEN = DatWrite;
            nextTo  = '0;
          end else begin
            nextREN   = 1'b0;
            nextWEN   = 1'b0;
            nextState = halt ? HALT : RUN;
          end
        end else if (flush) begin
          // halt is deliberately not sampled here; the next RUN cycle decides.
          nextREN   = 1'b0;
          nextWEN   = 1'b0;
          nextState = RUN;
        end else begin
          incI = fetchOk;
          if (TIMEOUT != 0) begin
            nextTo = toCnt + TO_ONE;
            if (nextTo == TO_LIMIT) begin
              nextREN   = 1'b0;
              nextWEN   = 1'b0;
              nextErr   = 1'b1;
              nextState = halt ? HALT : RUN;
            end
          end
        end
      end
      HALT: begin
        nextState = HALT;
      end
      default: begin
        nextState = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_req_unit_gen.sv
// Randomized bench for req_unit_gen: two instances (fetch hold on/off, different
// timeouts, narrow/wide counters) driven in lockstep and checked against a model.
module tb_req_unit_gen;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic DatRead = 1'b0, DatWrite = 1'b0, ihit = 1'b0, dhit = 1'b0;
  logic halt = 1'b0, flush = 1'b0;

  logic [1:0] reqiREN, reqdREN, reqdWEN, busyO, haltedO, toErr;
  logic [7:0]  icount0, dcount0;
  logic [31:0] icount1, dcount1;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instance configuration and reference state.
  bit          cfgHold[2] = '{1'b1, 1'b0};
  int          cfgTmo[2]  = '{4, 6};
  logic [31:0] cfgMask[2] = '{32'h0000_00FF, 32'hFFFF_FFFF};

  bit          mPend[2], mWr[2], mHalt[2], mErr[2];
  int          mAge[2];
  logic [31:0] mIc[2], mDc[2];

  req_unit_gen #(.CNT_W(8), .TO_W(8), .TIMEOUT(4), .IHOLD(1)) dut0 (
    .CLK(CLK), .nRST(nRST), .DatRead(DatRead), .DatWrite(DatWrite),
    .ihit(ihit), .dhit(dhit), .halt(halt), .flush(flush),
    .ReqiREN(reqiREN[0]), .ReqdREN(reqdREN[0]), .ReqdWEN(reqdWEN[0]),
    .busy(busyO[0]), .halted(haltedO[0]), .timeout_err(toErr[0]),
    .icount(icount0), .dcount(dcount0)
  );

  req_unit_gen #(.CNT_W(32), .TO_W(4), .TIMEOUT(6), .IHOLD(0)) dut1 (
    .CLK(CLK), .nRST(nRST), .DatRead(DatRead), .DatWrite(DatWrite),
    .ihit(ihit), .dhit(dhit), .halt(halt), .flush(flush),
    .ReqiREN(reqiREN[1]), .ReqdREN(reqdREN[1]), .ReqdWEN(reqdWEN[1]),
    .busy(busyO[1]), .halted(haltedO[1]), .timeout_err(toErr[1]),
    .icount(icount1), .dcount(dcount1)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mPend[k] = 0; mWr[k] = 0; mHalt[k] = 0; mErr[k] = 0;
      mAge[k] = 0; mIc[k] = 0; mDc[k] = 0;
    end
  endtask

  // Transaction-level model: a unit is idle, waiting on one request, or stopped.
  task automatic model_step(input bit dr, dw, ih, dh, hl, fl);
    bit fetch;
    for (int k = 0; k < 2; k++) begin
      if (mHalt[k]) continue;
      if (!mPend[k]) begin
        if (ih) mIc[k]++;
        if (ih && (dr || dw)) begin
          mPend[k] = 1; mWr[k] = dw; mAge[k] = 0;
        end else if (hl) mHalt[k] = 1;
      end else begin
        fetch = !cfgHold[k] && ih;
        if (dh) begin
          mDc[k]++;
          if (fetch) mIc[k]++;
          if (fetch && (dr || dw)) begin
            mWr[k] = dw; mAge[k] = 0;
          end else begin
            mPend[k] = 0;
            if (hl) mHalt[k] = 1;
          end
        end else if (fl) begin
          mPend[k] = 0;
        end else begin
          if (fetch) mIc[k]++;
          mAge[k]++;
          if (cfgTmo[k] != 0 && mAge[k] == cfgTmo[k]) begin
            mPend[k] = 0; mErr[k] = 1;
            if (hl) mHalt[k] = 1;
          end
        end
      end
    end
  endtask

  task automatic check_inst(input int k, input logic [31:0] ic, input logic [31:0] dc);
    check_val($sformatf("u%0d.ReqiREN", k), 32'(reqiREN[k]),
              32'(!mHalt[k] && (!mPend[k] || !cfgHold[k])));
    check_val($sformatf("u%0d.ReqdREN", k), 32'(reqdREN[k]), 32'(mPend[k] && !mWr[k]));
    check_val($sformatf("u%0d.ReqdWEN", k), 32'(reqdWEN[k]), 32'(mPend[k] && mWr[k]));
    check_val($sformatf("u%0d.busy", k), 32'(busyO[k]), 32'(mPend[k]));
    check_val($sformatf("u%0d.halted", k), 32'(haltedO[k]), 32'(mHalt[k]));
    check_val($sformatf("u%0d.timeout_err", k), 32'(toErr[k]), 32'(mErr[k]));
    check_val($sformatf("u%0d.icount", k), ic, mIc[k] & cfgMask[k]);
    check_val($sformatf("u%0d.dcount", k), dc, mDc[k] & cfgMask[k]);
  endtask

  task automatic check_all();
    check_inst(0, {24'h0, icount0}, {24'h0, dcount0});
    check_inst(1, icount1, dcount1);
  endtask

  // Called at a falling edge: check, drive, advance the model, move to next falling edge.
  task automatic cycle(input bit dr, dw, ih, dh, hl, fl);
    check_all();
    DatRead = dr; DatWrite = dw; ihit = ih; dhit = dh; halt = hl; flush = fl;
    model_step(dr, dw, ih, dh, hl, fl);
    @(negedge CLK);
  endtask

  // Reset lands between edges so its asynchronous effect is observed before any clock.
  task automatic do_reset();
    @(posedge CLK);
    #($urandom_range(1, 3));
    nRST = 1'b0;
    DatRead = 0; DatWrite = 0; ihit = 0; dhit = 0; halt = 0; flush = 0;
    #1;
    model_reset();
    check_all();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic rand_cycle(input int haltPct);
    bit ih, op;
    ih = ($urandom_range(0, 3) != 0);
    op = ($urandom_range(0, 1) == 1);
    cycle(op && ($urandom_range(0, 2) != 0), op && ($urandom_range(0, 2) == 0), ih,
          ($urandom_range(0, 4) == 0), ($urandom_range(1, 100) <= haltPct),
          ($urandom_range(0, 11) == 0));
  endtask

  initial begin
    model_reset();
    do_reset();

    // Idle fetches.
    repeat (5) cycle(0, 0, 1, 0, 0, 0);
    // Read with dhit three cycles later.
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Read+write collapses to a write, then flush cancels it.
    cycle(1, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    // Stuck read: both instances time out, error stays sticky.
    cycle(1, 0, 1, 0, 0, 0);
    repeat (8) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    // Back-to-back write on the no-hold instance, then halt after the next dhit.
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 1, 0);
    repeat (4) cycle(1, 0, 1, 1, 1, 1);
    cycle(0, 0, 0, 0, 0, 0);

    // Narrow counter wraps.
    do_reset();
    repeat (300) cycle(0, 0, 1, 0, 0, 0);

    // Random segments, including resets landing mid-request.
    for (int seg = 0; seg < 40; seg++) begin
      do_reset();
      repeat ($urandom_range(20, 80)) rand_cycle((seg % 4 == 0) ? 0 : 3);
    end
    check_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/req_unit_gen.md
Name: req_unit_gen

Overview:
- Parametrised memory request unit for the pipelined CPU. It sits between the datapath control signals (DatRead, DatWrite, halt, flush) and the cache/memory request interface.
- Issues instruction fetch requests, and latches one outstanding data read or write request per instruction fetch.
- Adds three features: optional instruction-fetch hold while a data request is pending, a data-request timeout with a sticky error flag, and a terminal HALT state.
- Maintains wrapping performance counters for completed instruction and data transactions.

Parameters:
- CNT_W, 32: width of icount and dcount performance counters.
- TO_W, 8: width of the internal timeout counter.
- TIMEOUT, 200: cycles a data request may stay outstanding without dhit; 0 disables the timeout; must be less than 2^TO_W.
- IHOLD, 1: 1 forces ReqiREN low while a data request is outstanding; 0 keeps fetching.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- DatRead  in  1  decoded instruction reads data memory.
- DatWrite  in  1  decoded instruction writes data memory.
- ihit  in  1  instruction memory transaction complete this cycle.
- dhit  in  1  data memory transaction complete this cycle.
- halt  in  1  halt instruction decoded (level).
- flush  in  1  pipeline squash; cancels the outstanding data request.
- ReqiREN  out  1  instruction read request.
- ReqdREN  out  1  data read request (registered).
- ReqdWEN  out  1  data write request (registered).
- busy  out  1  a data request is outstanding (state DATA).
- halted  out  1  unit is in HALT.
- timeout_err  out  1  sticky: a data request timed out.
- icount  out  CNT_W  count of accepted ihit.
- dcount  out  CNT_W  count of accepted dhit.

Behaviour:
- Reset (async, nRST=0): state RUN, ReqiREN=1, ReqdREN=0, ReqdWEN=0, busy=0, halted=0, timeout_err=0, icount=0, dcount=0, timeout counter=0. Reset overrides any in-flight request immediately.
- Output decode:
  - ReqiREN is combinational from state: RUN=1; DATA = (IHOLD ? 0 : 1); HALT=0.
  - ReqdREN/ReqdWEN are registered.
  - ReqdREN and ReqdWEN are never both 1. If DatRead and DatWrite are both set, only ReqdWEN is latched.
- RUN:
  - ihit with (DatRead or DatWrite) -> DATA next cycle. Latch ReqdREN/ReqdWEN; clear the timeout counter; icount+1.
  - ihit without a data op -> stay RUN; icount+1.
  - halt=1 with no qualifying ihit data request -> HALT.
  - If halt and an ihit data request arrive in the same cycle, DATA takes priority. halt is re-evaluated when the request completes.
  - dhit and flush are ignored in RUN.
- DATA (priority order, highest first):
  1. dhit: dcount+1; clear ReqdREN/ReqdWEN; go to HALT if halt=1, else RUN. Exception: if IHOLD=0 and ihit with a data op occurs in the same cycle, stay in DATA with the newly latched request, icount+1, and timeout counter cleared.
  2. flush: clear ReqdREN/ReqdWEN; go RUN; no counter increments. The HALT decision is deferred to the next RUN cycle.
  3. Timeout (TIMEOUT != 0): the counter increments each DATA cycle without dhit. On the TIMEOUT-th consecutive such cycle, clear ReqdREN/ReqdWEN, set timeout_err=1, and go to HALT if halt=1, else RUN. The request is therefore visible for exactly TIMEOUT cycles.
  4. Otherwise hold the request.
  - ihit in DATA with IHOLD=1 is ignored and does not increment icount.
  - ihit in DATA with IHOLD=0 and no dhit: icount+1; the pending request is kept unchanged.
- HALT: all requests 0, halted=1, busy=0. Terminal state; only nRST exits. ihit, dhit, flush, DatRead and DatWrite are ignored. Counters freeze.
- Counters wrap modulo 2^CNT_W with no saturation.
- timeout_err is cleared only by reset.
- busy = (state == DATA).

Test Plan:
- Reset then idle with ihit=1 and no data op for 5 cycles -> ReqiREN=1, ReqdREN=ReqdWEN=0, icount=5, dcount=0.
- ihit with DatRead=1, dhit 3 cycles later (IHOLD=1) -> ReqdREN=1 and ReqiREN=0 for 3 cycles, then ReqdREN=0, ReqiREN=1, dcount=1, busy falls with ReqdREN.
- ihit with DatRead=DatWrite=1 -> only ReqdWEN=1. Then flush with dhit low -> ReqdWEN=0 next cycle, dcount unchanged, state RUN.
- TIMEOUT=4, data request with no dhit -> ReqdREN high exactly 4 cycles, then 0; timeout_err=1 and stays 1 through later normal transactions until nRST.
- IHOLD=0: ihit+DatWrite while DATA coincides with dhit -> ReqdWEN stays 1, icount and dcount both +1. halt=1 during the next pending request -> HALT after its dhit; ReqiREN=0, halted=1, counters frozen despite ihit pulses.
- Assert nRST mid-DATA (asynchronously, between edges) -> ReqdREN/ReqdWEN drop immediately, ReqiREN=1, counters 0, timeout_err=0.
